matrix_seq: RTL
===============

Name: matrix_seq

Overview:
- Access sequencer directly upstream of the 1024x1024 matrix datapath.
- Accepts block read/write commands over a valid/ready command port.
- Converts each 20-bit linear word index to a one-hot RAM select (index[19:16]) and a 16-bit row address (index[15:0]), driving the datapath's ram_sel/a/din/we.
- Streams write data in and read data out with valid/ready handshakes at up to one word per cycle.

Parameters:
- DATA_W, 32, matrix word width; must equal datapath din/dout width.
- RAM_AW, 16, per-RAM address width.
- NUM_RAM, 16, number of RAMs; power of two; IDX_W = RAM_AW + log2(NUM_RAM) = 20.

Ports:
- CLK  in  1  clock.
- RST_L  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = write, 1 = read.
- cmd_base  in  IDX_W  first linear index.
- cmd_len  in  IDX_W  word count minus one.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  write word accepted.
- wr_data  in  DATA_W  write word.
- rd_valid  out  1  read word available.
- rd_ready  in  1  read word consumed.
- rd_data  out  DATA_W  read word.
- busy  out  1  command in progress or write pulse pending.
- ram_sel  out  NUM_RAM  one-hot RAM select to datapath.
- a  out  RAM_AW  RAM row address.
- din  out  DATA_W  RAM write data.
- we  out  NUM_RAM  per-RAM write enable.
- dout  in  DATA_W  datapath read data; combinational from ram_sel/a.

Behaviour:
- Clock and reset: single clock CLK. Reset is synchronous, active-low on RST_L; it is sampled only at the CLK rising edge.
- Reset values:
  - State = IDLE.
  - ram_sel = 16'h0001. ram_sel is always exactly one-hot, never zero, including during reset.
  - a = 0, din = 0, we = 0.
  - rd_valid = 0, rd_data = 0, busy = 0.
  - Reset mid-command aborts immediately; no further we pulses are issued.
- Internal state: idx (IDX_W) and remaining count cnt (IDX_W).
  - idx increments modulo 2^IDX_W, so 0xFFFFF wraps to 0x00000.
  - ram_sel = onehot(idx[19:16]) and a = idx[15:0] are registered.
- States: IDLE, WR, RD, RD_FLUSH.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: load idx = cmd_base, cnt = cmd_len. Go to WR if cmd_op = 0, otherwise RD.
- WR:
  - wr_ready = 1.
  - On each wr_valid & wr_ready (handshake at cycle T), at cycle T+1: we = onehot(idx[19:16]), a = idx[15:0], din = wr_data. The RAM writes at the T+1 -> T+2 edge.
  - we is high for exactly one cycle per handshake; it is 0 in every cycle without a preceding handshake.
  - After the handshake, idx++ and cnt--.
  - The handshake with cnt = 0 moves the state to IDLE. busy stays 1 during the final we cycle.
- RD:
  - ram_sel/a already present idx, so dout is valid in the same cycle.
  - When (!rd_valid | rd_ready): rd_data <= dout, rd_valid <= 1, idx++, cnt--.
  - If that capture had cnt = 0, go to RD_FLUSH.
  - Sustains 1 word/cycle while rd_ready = 1.
  - With rd_ready = 0 and rd_valid = 1: rd_data holds and the address holds.
- RD_FLUSH: on rd_ready, rd_valid <= 0 and state goes to IDLE.
- Timing rules:
  - busy = (state != IDLE) | (we != 0).
  - A new command is accepted no earlier than the cycle after returning to IDLE.
- Limits: cmd_len = 0 transfers one word; cmd_len = 0xFFFFF transfers the whole matrix.
- Ignored inputs: wr_valid outside WR, and rd_ready when rd_valid = 0.

Optional Feature:
- Macro: MATRIX_SEQ_BOUND_CHK_EN.
- When defined:
  - Adds output cmd_err (1 bit, reset 0).
  - A command with cmd_base + cmd_len > 0xFFFFF (computed at IDX_W+1 bits) is consumed in IDLE, pulses cmd_err for one cycle, and stays in IDLE.
  - No we pulses and no rd_valid result from such a command.
- When undefined: no cmd_err port; the index wraps modulo 2^20 as described above.

Test Plan:
- Write then read back, single word:
  - Write cmd base=0x12345, len=0, wr_data=0xDEADBEEF: one-cycle we=16'h0002, a=0x2345, din=0xDEADBEEF.
  - Read cmd base=0x12345, len=0: rd_data=0xDEADBEEF with rd_valid asserted, then IDLE.
- Burst across RAM boundary: write base=0x0FFFE, len=3, data 1..4 -> we sequence 0x0001, 0x0001, 0x0002, 0x0002 with a = 0xFFFE, 0xFFFF, 0x0000, 0x0001; read back returns 1, 2, 3, 4.
- Read backpressure: read len=7 with rd_ready toggled 1,0,0,1,... -> all 8 words delivered in order, none duplicated or dropped; rd_data stable whenever rd_valid=1 & rd_ready=0.
- Wrap: base=0xFFFFF, len=1 -> ram_sel 16'h8000 then 16'h0001, a = 0xFFFF then 0x0000. With MATRIX_SEQ_BOUND_CHK_EN: one-cycle cmd_err pulse instead, no we pulses, no rd_valid.
- Reset mid-write: assert RST_L=0 after 2 of 5 handshakes -> next cycle we=0, ram_sel=16'h0001, busy=0, cmd_ready=1; a subsequent write command completes normally.

Source files
------------

// File: rtl/matrix_seq.sv
// matrix_seq: access sequencer in front of the 1024x1024 matrix datapath.
// Takes block read/write commands, walks a 20-bit linear word index and turns
// it into a one-hot RAM select plus row address. Streams write and read words
// at up to one per cycle.
//
// Ports:
//   CLK, RST_L                       clock, synchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only when idle)
//   cmd_op                           0 = write, 1 = read
//   cmd_base, cmd_len                first linear index, word count minus one
//   wr_valid/wr_ready/wr_data        write word stream
//   rd_valid/rd_ready/rd_data        read word stream
//   busy                             command running or write pulse pending
//   ram_sel, a, din, we              registered datapath controls
//   dout                             datapath read data (combinational from ram_sel/a)
//   cmd_err                          only with MATRIX_SEQ_BOUND_CHK_EN: one-cycle
//                                    pulse for a command running past the matrix end
module matrix_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_AW  = 16,
    parameter int unsigned NUM_RAM = 16,
    localparam int unsigned SEL_W  = $clog2(NUM_RAM),
    localparam int unsigned IDX_W  = RAM_AW + SEL_W
) (
    input  logic               CLK,
    input  logic               RST_L,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [IDX_W-1:0]   cmd_base,
    input  logic [IDX_W-1:0]   cmd_len,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [DATA_W-1:0]  rd_data,
    output logic               busy,
`ifdef MATRIX_SEQ_BOUND_CHK_EN
    output logic               cmd_err,
`endif
    output logic [NUM_RAM-1:0] ram_sel,
    output logic [RAM_AW-1:0]  a,
    output logic [DATA_W-1:0]  din,
    output logic [NUM_RAM-1:0] we,
    input  logic [DATA_W-1:0]  dout
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR       = 2'd1,
        ST_RD       = 2'd2,
        ST_RD_FLUSH = 2'd3
    } state_t;

    localparam logic [NUM_RAM-1:0] SEL_RST = {{(NUM_RAM-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_cnt;
    logic [NUM_RAM-1:0]  r_ram_sel;
    logic [NUM_RAM-1:0]  r_we;
    logic [RAM_AW-1:0]   r_a;
    logic [DATA_W-1:0]   r_din;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_busy;

    logic                w_cmd_acc;
    logic                w_cmd_go;
    logic                w_wr_hs;
    logic                w_rd_cap;
    logic                w_rd_pop;
    logic                w_last;
    logic [IDX_W-1:0]    w_idx_inc;
    logic [NUM_RAM-1:0]  w_we_nxt;

    function automatic logic [NUM_RAM-1:0] f_onehot(input logic [SEL_W-1:0] sel);
        f_onehot = SEL_RST << sel;
    endfunction

    assign w_cmd_acc = (r_state == ST_IDLE) & cmd_valid;
    assign w_wr_hs   = (r_state == ST_WR) & wr_valid;
    // A read capture happens whenever the output slot is empty or being drained.
    assign w_rd_cap  = (r_state == ST_RD) & (~r_rd_valid | rd_ready);
    assign w_rd_pop  = (r_state == ST_RD_FLUSH) & rd_ready;
    assign w_last    = (r_cnt == '0);
    assign w_idx_inc = r_idx + IDX_W'(1);

`ifdef MATRIX_SEQ_BOUND_CHK_EN
    logic [IDX_W:0] w_end_sum;
    logic           w_cmd_bad;
    logic           r_cmd_err;

    // Carry out of base+len means the block runs past the last word.
    assign w_end_sum = {1'b0, cmd_base} + {1'b0, cmd_len};
    assign w_cmd_bad = w_end_sum[IDX_W];
    assign w_cmd_go  = w_cmd_acc & ~w_cmd_bad;
    assign cmd_err   = r_cmd_err;

    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_acc & w_cmd_bad;
        end
    end
`else
    assign w_cmd_go = w_cmd_acc;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_cmd_go) w_state_nxt = cmd_op ? ST_RD : ST_WR;
            ST_WR:       if (w_wr_hs && w_last) w_state_nxt = ST_IDLE;
            ST_RD:       if (w_rd_cap && w_last) w_state_nxt = ST_RD_FLUSH;
            ST_RD_FLUSH: if (rd_ready) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs and the write-enable for the next cycle.
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        w_we_nxt  = '0;
        if (r_state == ST_IDLE) cmd_ready = 1'b1;
        if (r_state == ST_WR)   wr_ready  = 1'b1;
        if (w_wr_hs)            w_we_nxt  = f_onehot(r_idx[IDX_W-1 -: SEL_W]);
    end

    // Index walk and datapath/read-port registers. Writes present the index of
    // the handshake; reads present the index of the next word to fetch.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_ram_sel  <= SEL_RST;
            r_a        <= '0;
            r_din      <= '0;
            r_we       <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_we   <= w_we_nxt;
            r_busy <= (w_state_nxt != ST_IDLE) | (|w_we_nxt);
            if (w_cmd_go) begin
                r_idx     <= cmd_base;
                r_cnt     <= cmd_len;
                r_ram_sel <= f_onehot(cmd_base[IDX_W-1 -: SEL_W]);
                r_a       <= cmd_base[RAM_AW-1:0];
            end else if (w_wr_hs) begin
                r_idx     <= w_idx_inc;
                r_cnt     <= r_cnt - IDX_W'(1);
                r_ram_sel <= f_onehot(r_idx[IDX_W-1 -: SEL_W]);
                r_a       <= r_idx[RAM_AW-1:0];
                r_din     <= wr_data;
            end else if (w_rd_cap) begin
                r_idx      <= w_idx_inc;
                r_cnt      <= r_cnt - IDX_W'(1);
                r_ram_sel  <= f_onehot(w_idx_inc[IDX_W-1 -: SEL_W]);
                r_a        <= w_idx_inc[RAM_AW-1:0];
                r_rd_data  <= dout;
                r_rd_valid <= 1'b1;
            end else if (w_rd_pop) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign ram_sel  = r_ram_sel;
    assign a        = r_a;
    assign din      = r_din;
    assign we       = r_we;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign busy     = r_busy;

endmodule
